// File: rtl/myo_spi_pkg.sv
// ----------------------------------------------------------------------------
// myo_spi_pkg - shared types and frame layout for the myo SPI frame master (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package myo_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int          FRAME_WORDS  = 7;
  localparam logic [15:0] HDR_MOTOR_ON = 16'h8000;

  localparam int RX_STATUS  = 0;
  localparam int RX_POS_HI  = 1;
  localparam int RX_POS_LO  = 2;
  localparam int RX_VEL     = 3;
  localparam int RX_CUR     = 4;
  localparam int RX_DISP_HI = 5;
  localparam int RX_DISP_LO = 6;

  // Outgoing word for a given frame slot: header, PWM reference, then padding.
  function automatic logic [15:0] tx_word_for(input logic [2:0]  idx,
                                              input logic        en,
                                              input logic [15:0] pwm);
    logic [15:0] w;
    w = 16'h0000;
    if (idx == 3'd0)      w = en ? HDR_MOTOR_ON : 16'h0000;
    else if (idx == 3'd1) w = pwm;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/myo_spi_frame_master_shifter.sv
// ----------------------------------------------------------------------------
// spi_word_shifter - one 16-bit SPI mode-0 word with CLK_DIV half-period divider (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module spi_word_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic [15:0] tx_word,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic [15:0] rx_word,
  output logic        done
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       half_q, half_d;
  logic [5:0]       half_nxt;
  logic             sclk_q, sclk_d;
  logic [15:0]      sr_q, sr_d;
  logic [15:0]      rx_q, rx_d;

  // A word spans 33 half-periods from go: two idle halves (SETUP plus the
  // lead-in), then rising edges on even halves 2..32 and falling on odd 3..33.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    half_d   = half_q;
    sclk_d   = sclk_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    done     = 1'b0;
    half_nxt = half_q + 6'd1;

    if (go) begin
      active_d = 1'b1;
      div_d    = '0;
      half_d   = '0;
      sclk_d   = 1'b0;
      sr_d     = tx_word;
    end else if (active_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d  = '0;
        half_d = half_nxt;
        if (half_nxt >= 6'd2) begin
          if (!half_nxt[0]) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], miso};
          end else begin
            sclk_d = 1'b0;
            sr_d   = {sr_q[14:0], 1'b0};
          end
        end
        if (half_nxt == 6'd33) begin
          active_d = 1'b0;
          done     = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      sclk_q   <= 1'b0;
      sr_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sclk_q   <= sclk_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = sr_q[15];
  assign rx_word = rx_q;

endmodule

`default_nettype wire

// File: rtl/myo_spi_frame_master.sv
// ----------------------------------------------------------------------------
// myo_spi_frame_master - 7-word SPI frame exchange with a myo motor board (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module myo_spi_frame_master #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               enable_motor,
  input  logic signed [15:0] pwmRef,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic               ss_n,
  output logic               busy,
  output logic        [15:0] status,
  output logic signed [31:0] position,
  output logic signed [15:0] velocity,
  output logic signed [15:0] current,
  output logic signed [31:0] displacement,
  output logic               update_controller,
  output logic        [15:0] frame_count
);

  import myo_spi_pkg::*;

  localparam logic [2:0] LAST_WORD = 3'(FRAME_WORDS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  word_q, word_d;
  logic        en_q, en_d;
  logic [15:0] pwm_q, pwm_d;
  logic [15:0] buf_q [FRAME_WORDS-1];
  logic [15:0] buf_d [FRAME_WORDS-1];
  logic [15:0] status_q, status_d;
  logic [31:0] position_q, position_d;
  logic [15:0] velocity_q, velocity_d;
  logic [15:0] current_q, current_d;
  logic [31:0] displacement_q, displacement_d;
  logic        update_q, update_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        busy_q, busy_d;
  logic        ss_n_q, ss_n_d;

  logic        accept;
  logic        go;
  logic [15:0] tx_word;
  logic        sh_done;
  logic [15:0] sh_rx;

  spi_word_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock   (clock),
    .reset   (reset),
    .go      (go),
    .tx_word (tx_word),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .rx_word (sh_rx),
    .done    (sh_done)
  );

  // The GAP state is named through the package because the GAP parameter
  // shadows the wildcard-imported enum literal.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    word_d         = word_q;
    en_d           = en_q;
    pwm_d          = pwm_q;
    buf_d          = buf_q;
    status_d       = status_q;
    position_d     = position_q;
    velocity_d     = velocity_q;
    current_d      = current_q;
    displacement_d = displacement_q;
    frame_count_d  = frame_count_q;
    update_d       = 1'b0;
    accept         = 1'b0;
    go             = 1'b0;
    tx_word        = 16'h0000;

    unique case (state_q)
      IDLE: accept = start;

      SETUP: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      SHIFT: begin
        if (sh_done) begin
          if (word_q == LAST_WORD) begin
            // Publish the whole frame at once; the last word bypasses the buffer.
            state_d        = DONE;
            status_d       = buf_q[RX_STATUS];
            position_d     = {buf_q[RX_POS_HI], buf_q[RX_POS_LO]};
            velocity_d     = buf_q[RX_VEL];
            current_d      = buf_q[RX_CUR];
            displacement_d = {buf_q[RX_DISP_HI], sh_rx};
            update_d       = 1'b1;
            frame_count_d  = frame_count_q + 16'd1;
          end else begin
            buf_d[word_q] = sh_rx;
            state_d       = myo_spi_pkg::GAP;
            cnt_d         = '0;
          end
        end
      end

      myo_spi_pkg::GAP: begin
        if (cnt_q == 16'(GAP - 1)) begin
          state_d = SETUP;
          cnt_d   = '0;
          word_d  = word_q + 3'd1;
          go      = 1'b1;
          tx_word = tx_word_for(word_d, en_q, pwm_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Sampling start here as well lets a held start run frames back to back.
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end

      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SETUP;
      cnt_d   = '0;
      word_d  = 3'd0;
      en_d    = enable_motor;
      pwm_d   = pwmRef;
      go      = 1'b1;
      tx_word = tx_word_for(3'd0, enable_motor, pwmRef);
    end

    busy_d = (state_d != IDLE);
    ss_n_d = !((state_d == SETUP) || (state_d == SHIFT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      word_q         <= '0;
      en_q           <= 1'b0;
      pwm_q          <= '0;
      for (int i = 0; i < FRAME_WORDS - 1; i++) buf_q[i] <= '0;
      status_q       <= '0;
      position_q     <= '0;
      velocity_q     <= '0;
      current_q      <= '0;
      displacement_q <= '0;
      update_q       <= 1'b0;
      frame_count_q  <= '0;
      busy_q         <= 1'b0;
      ss_n_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      word_q         <= word_d;
      en_q           <= en_d;
      pwm_q          <= pwm_d;
      buf_q          <= buf_d;
      status_q       <= status_d;
      position_q     <= position_d;
      velocity_q     <= velocity_d;
      current_q      <= current_d;
      displacement_q <= displacement_d;
      update_q       <= update_d;
      frame_count_q  <= frame_count_d;
      busy_q         <= busy_d;
      ss_n_q         <= ss_n_d;
    end
  end

  assign ss_n              = ss_n_q;
  assign busy              = busy_q;
  assign status            = status_q;
  assign position          = position_q;
  assign velocity          = velocity_q;
  assign current           = current_q;
  assign displacement      = displacement_q;
  assign update_controller = update_q;
  assign frame_count       = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_myo_spi_frame_master.sv
// ----------------------------------------------------------------------------
// tb_myo_spi_frame_master - randomized frames against a behavioural SPI slave (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_myo_spi_frame_master;

  localparam int CD = 2;
  localparam int GP = 2;
  localparam int F  = 7 * 33 * CD + 6 * GP;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               enable_motor = 1'b0;
  logic signed [15:0] pwmRef = '0;
  logic               miso = 1'b0;
  wire                sclk, mosi, ss_n, busy, update_controller;
  wire         [15:0] status, frame_count;
  wire signed  [31:0] position, displacement;
  wire signed  [15:0] velocity, current;

  myo_spi_frame_master #(.CLK_DIV(CD), .GAP(GP)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .enable_motor      (enable_motor),
    .pwmRef            (pwmRef),
    .miso              (miso),
    .sclk              (sclk),
    .mosi              (mosi),
    .ss_n              (ss_n),
    .busy              (busy),
    .status            (status),
    .position          (position),
    .velocity          (velocity),
    .current           (current),
    .displacement      (displacement),
    .update_controller (update_controller),
    .frame_count       (frame_count)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_fc = 16'h0000;

  // Behavioural mode-0 slave: one word per ss_n window, words served in order.
  logic [15:0] slv_words [7];
  logic [15:0] s_tx = '0, s_rx = '0;
  int          s_widx = 0;
  bit          s_active = 1'b0;
  logic [15:0] cap_q [$];

  always @(negedge ss_n) begin
    s_active = 1'b1;
    s_tx     = slv_words[s_widx];
    s_rx     = '0;
    miso     = s_tx[15];
  end
  always @(posedge sclk) if (s_active) s_rx = {s_rx[14:0], mosi};
  always @(negedge sclk) if (s_active) begin
    s_tx = {s_tx[14:0], 1'b0};
    miso = s_tx[15];
  end
  always @(posedge ss_n) if (s_active) begin
    s_active = 1'b0;
    cap_q.push_back(s_rx);
    s_widx = (s_widx == 6) ? 0 : s_widx + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_clear();
    cap_q.delete();
    s_widx   = 0;
    s_active = 1'b0;
  endtask

  task automatic randomize_slave();
    for (int i = 0; i < 7; i++) slv_words[i] = 16'($urandom);
  endtask

  function automatic logic [15:0] exp_tx(input int i, input logic en, input logic [15:0] pwm);
    if (i == 0) return en ? 16'h8000 : 16'h0000;
    if (i == 1) return pwm;
    return 16'h0000;
  endfunction

  // One complete frame: timing of strobe/busy, published data, transmitted words.
  task automatic do_frame(input logic en, input logic [15:0] pwm, input int pulse_at, input string tag);
    int strobe_bad = 0;
    int busy_bad   = 0;
    slave_clear();
    @(negedge clock);
    enable_motor = en;
    pwmRef       = pwm;
    start        = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= F + 8; k++) begin
      @(negedge clock);
      if (k == 0) begin
        start = 1'b0;
        check({tag, " ss_n low in cycle 0"}, 64'(ss_n), 64'd0);
      end
      if (k == 1) begin
        enable_motor = ~en;
        pwmRef       = ~pwm;
      end
      if (k == pulse_at) begin
        pwmRef = 16'h7FFF;
        start  = 1'b1;
      end
      if (k == pulse_at + 1) start = 1'b0;
      if (update_controller !== (k == F)) strobe_bad++;
      if (busy !== (k <= F)) busy_bad++;
      if (k == F) begin
        check({tag, " status"}, {status}, slv_words[0]);
        check({tag, " position"}, {position}, {slv_words[1], slv_words[2]});
        check({tag, " velocity"}, {velocity}, slv_words[3]);
        check({tag, " current"}, {current}, slv_words[4]);
        check({tag, " displacement"}, {displacement}, {slv_words[5], slv_words[6]});
      end
    end
    exp_fc = exp_fc + 16'd1;
    check({tag, " strobe only in cycle F"}, 64'(strobe_bad), 64'd0);
    check({tag, " busy window"}, 64'(busy_bad), 64'd0);
    check({tag, " frame_count"}, {frame_count}, exp_fc);
    check({tag, " tx word count"}, 64'(cap_q.size()), 64'd7);
    for (int i = 0; i < 7 && i < cap_q.size(); i++)
      check({tag, " tx word"}, {cap_q[i]}, exp_tx(i, en, pwm));
  endtask

  initial begin
    int          strobe_at [$];
    int          runs [$];
    int          hi_run;
    int          bad;
    logic        en_r;
    logic [15:0] pwm_r;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset sclk", 64'(sclk), 64'd0);
    check("reset ss_n", 64'(ss_n), 64'd1);
    check("reset mosi", 64'(mosi), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset update", 64'(update_controller), 64'd0);
    check("reset data", {status, velocity, current}, 64'd0);
    check("reset wide data", {position, displacement}, 64'd0);
    check("reset frame_count", {frame_count}, 64'd0);
    reset = 1'b0;

    // Loopback readback with fixed words, then header with motor off
    slv_words = '{16'h00A5, 16'h1234, 16'h5678, 16'hFFF0, 16'h0100, 16'h0000, 16'h0200};
    do_frame(1'b1, 16'hFED4, -1, "loopback");
    check("loopback velocity -16", {velocity}, 16'hFFF0);
    check("loopback position", {position}, 32'h12345678);
    randomize_slave();
    do_frame(1'b0, 16'($urandom), -1, "tx_en0");

    // Start pulse and pwm change mid-frame are ignored
    randomize_slave();
    do_frame(1'b1, 16'hFED4, 100, "snapshot");

    repeat (3) begin
      randomize_slave();
      en_r  = 1'($urandom);
      pwm_r = 16'($urandom);
      do_frame(en_r, pwm_r, -1, "random");
    end

    // Reset during word 3 (cycle 232 is inside an sclk-high phase)
    randomize_slave();
    slave_clear();
    @(negedge clock);
    enable_motor = 1'b1;
    pwmRef       = 16'h1111;
    start        = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= 232; k++) begin
      @(negedge clock);
      if (k == 0) start = 1'b0;
    end
    check("pre-reset sclk high", 64'(sclk), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset ss_n", 64'(ss_n), 64'd1);
    check("midreset sclk", 64'(sclk), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset data", {status, velocity, current, frame_count}, 64'd0);
    check("midreset wide data", {position, displacement}, 64'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (update_controller !== 1'b0) bad++;
    end
    check("midreset no strobe", 64'(bad), 64'd0);
    reset  = 1'b0;
    exp_fc = 16'h0000;
    slave_clear();
    randomize_slave();
    do_frame(1'b1, 16'($urandom), -1, "after reset");

    // frame_count wrap
    @(negedge clock);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_count_q;
    exp_fc = 16'hFFFF;
    #1;
    check("preload frame_count", {frame_count}, 16'hFFFF);
    randomize_slave();
    do_frame(1'b0, 16'($urandom), -1, "wrap");

    // Back-to-back frames with start held
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    slave_clear();
    randomize_slave();
    en_r  = 1'($urandom);
    pwm_r = 16'($urandom);
    @(negedge clock);
    enable_motor = en_r;
    pwmRef       = pwm_r;
    start        = 1'b1;
    @(posedge clock);
    hi_run = 0;
    bad    = 0;
    for (int k = 0; k <= 3 * (F + 1) + 2; k++) begin
      @(negedge clock);
      if (k == 2 * (F + 1) + 1) start = 1'b0;
      if (update_controller === 1'b1) begin
        strobe_at.push_back(k);
        if ({status} !== {48'd0, slv_words[0]} || {position} !== {slv_words[1], slv_words[2]}) bad++;
      end
      if (ss_n === 1'b1) hi_run++;
      else if (hi_run > 0) begin
        runs.push_back(hi_run);
        hi_run = 0;
      end
      if (k == 3 * (F + 1)) check("b2b busy after last", 64'(busy), 64'd0);
    end
    check("b2b strobe count", 64'(strobe_at.size()), 64'd3);
    for (int i = 0; i < 3 && i < strobe_at.size(); i++)
      check("b2b strobe cycle", 64'(strobe_at[i]), 64'(F + i * (F + 1)));
    check("b2b data", 64'(bad), 64'd0);
    check("b2b frame_count", {frame_count}, 64'd3);
    check("b2b ss_n high runs", 64'(runs.size()), 64'd20);
    bad = 0;
    for (int i = 0; i < runs.size(); i++)
      if (runs[i] != (((i == 6) || (i == 13)) ? 1 : GP)) bad++;
    check("b2b ss_n run lengths", 64'(bad), 64'd0);
    check("b2b tx count", 64'(cap_q.size()), 64'd21);
    bad = 0;
    for (int i = 0; i < cap_q.size(); i++)
      if (cap_q[i] !== exp_tx(i % 7, en_r, pwm_r)) bad++;
    check("b2b tx words", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
